// File: rtl/decoder_scan_ctrl_if.sv
// Handshake/bus bundle between a scan requester and decoder_scan_ctrl.
// The optional dir signal exists only when SCAN_REVERSE_EN is defined.
interface decoder_scan_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             start;
  logic             stop;
  logic             cont;
  logic [3:0]       mask;
  logic [DIV_W-1:0] div;
`ifdef SCAN_REVERSE_EN
  logic             dir;
`endif
  logic [1:0]       addr;
  logic             valid;
  logic             busy;
  logic             done;

  // Requester side: issues commands, observes scan progress.
  modport master (
    output start, stop, cont, mask, div,
`ifdef SCAN_REVERSE_EN
    output dir,
`endif
    input  addr, valid, busy, done
  );

  // Controller side.
  modport slave (
    input  start, stop, cont, mask, div,
`ifdef SCAN_REVERSE_EN
    input  dir,
`endif
    output addr, valid, busy, done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Scan controller stepping a 2-to-4 decoder select through its unmasked
// lines, each held div+1 cycles, as a single sweep or a continuous scan.
// Optional macro SCAN_REVERSE_EN adds a latched dir input (1 = descending).
module decoder_scan_ctrl #(
  parameter int DIV_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_scan_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       addr_q, addr_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       mask_q, mask_d;
  logic             cont_q, cont_d;
  logic             dir_q, dir_d;
  logic             dir_in;
  logic [2:0]       nxt;

`ifdef SCAN_REVERSE_EN
  assign dir_in = bus.dir;
`else
  assign dir_in = 1'b0;
`endif

  // Lowest unmasked index (only meaningful when some line is unmasked).
  function automatic logic [1:0] first_up(input logic [3:0] m);
    logic [1:0] r = 2'd0;
    for (int i = 3; i >= 0; i--) if (!m[i]) r = 2'(i);
    return r;
  endfunction

  // Highest unmasked index.
  function automatic logic [1:0] first_down(input logic [3:0] m);
    logic [1:0] r = 2'd0;
    for (int i = 0; i < 4; i++) if (!m[i]) r = 2'(i);
    return r;
  endfunction

  // {found, index} of the nearest unmasked line above cur.
  function automatic logic [2:0] next_up(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r = 3'd0;
    for (int i = 3; i >= 0; i--) if (i > int'(cur) && !m[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction

  // {found, index} of the nearest unmasked line below cur.
  function automatic logic [2:0] next_down(input logic [3:0] m, input logic [1:0] cur);
    logic [2:0] r = 3'd0;
    for (int i = 0; i < 4; i++) if (i < int'(cur) && !m[i]) r = {1'b1, 2'(i)};
    return r;
  endfunction

  // Next-state and registered-output computation for the scan FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    div_d   = div_q;
    mask_d  = mask_q;
    cont_d  = cont_q;
    dir_d   = dir_q;
    nxt     = dir_q ? next_down(mask_q, addr_q) : next_up(mask_q, addr_q);
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          mask_d = bus.mask;
          div_d  = bus.div;
          cont_d = bus.cont;
          dir_d  = dir_in;
          if (&bus.mask) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = DWELL;
            addr_d  = dir_in ? first_down(bus.mask) : first_up(bus.mask);
            valid_d = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = bus.div;
          end
        end
      end
      DWELL: begin
        if (bus.stop) begin
          state_d = IDLE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIV_W'(1);
        end else if (nxt[2]) begin
          addr_d = nxt[1:0];
          cnt_d  = div_q;
        end else if (cont_q) begin
          // Wrap; may land on the current line when only one is unmasked.
          addr_d = dir_q ? first_down(mask_q) : first_up(mask_q);
          cnt_d  = div_q;
        end else begin
          state_d = DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // All state and outputs registered; reset clears everything, including latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 2'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      div_q   <= '0;
      mask_q  <= 4'd0;
      cont_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      mask_q  <= mask_d;
      cont_q  <= cont_d;
      dir_q   <= dir_d;
    end
  end

  assign bus.addr  = addr_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl with hand-computed expectations.
module tb_decoder_scan_ctrl;
  localparam int DIV_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  decoder_scan_ctrl_if #(.DIV_W(DIV_W)) bus ();

  decoder_scan_ctrl #(.DIV_W(DIV_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are then observed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [1:0] a, input logic v,
                         input logic b, input logic d);
    check({tag, ".addr"},  {30'd0, bus.addr}, {30'd0, a});
    check({tag, ".valid"}, {31'd0, bus.valid}, {31'd0, v});
    check({tag, ".busy"},  {31'd0, bus.busy}, {31'd0, b});
    check({tag, ".done"},  {31'd0, bus.done}, {31'd0, d});
  endtask

  task automatic go(input logic [3:0] m, input logic [7:0] dv, input logic c);
    bus.mask  = m;
    bus.div   = dv;
    bus.cont  = c;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [1:0] seq_c [13];
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.cont  = 1'b0;
    bus.mask  = 4'd0;
    bus.div   = '0;
`ifdef SCAN_REVERSE_EN
    bus.dir   = 1'b0;
`endif
    step();
    step();
    chk_out("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    chk_out("idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Full single sweep, div=1: 0,0,1,1,2,2,3,3 then done.
    go(4'b0000, 8'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("sweep%0d", i), 2'(i / 2), 1'b1, 1'b1, 1'b0);
      step();
    end
    chk_out("sweep_done", 2'd3, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("sweep_idle", 2'd3, 1'b0, 1'b0, 1'b0);

    // Masked sweep 0101, div=0: lines 1 then 3, done on the 3rd cycle.
    go(4'b0101, 8'd0, 1'b0);
    chk_out("m5_a", 2'd1, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("m5_b", 2'd3, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("m5_done", 2'd3, 1'b0, 1'b0, 1'b1);
    step();

    // All lines masked: done immediately, never valid.
    go(4'hF, 8'd4, 1'b0);
    chk_out("mF_done", 2'd3, 1'b0, 1'b0, 1'b1);
    step();
    chk_out("mF_idle", 2'd3, 1'b0, 1'b0, 1'b0);

    // Continuous, mask 1000, div=2, stop during line 1 of the second pass.
    seq_c = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2,
              2'd0, 2'd0, 2'd0, 2'd1};
    go(4'b1000, 8'd2, 1'b1);
    for (int i = 0; i < 13; i++) begin
      chk_out($sformatf("cont%0d", i), seq_c[i], 1'b1, 1'b1, 1'b0);
      if (i < 12) step();
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_out("cont_stop", 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("cont_nodone", 2'd1, 1'b0, 1'b0, 1'b0);

    // start together with stop in idle: nothing starts.
    bus.stop = 1'b1;
    go(4'b0000, 8'd0, 1'b0);
    bus.stop = 1'b0;
    chk_out("ss_idle", 2'd1, 1'b0, 1'b0, 1'b0);
    step();
    chk_out("ss_idle2", 2'd1, 1'b0, 1'b0, 1'b0);

    // Start pulse and input changes mid-scan must not disturb the sweep.
    go(4'b0000, 8'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk_out($sformatf("ign%0d", i), 2'(i / 2), 1'b1, 1'b1, 1'b0);
      if (i == 2) begin
        bus.start = 1'b1;
        bus.div   = 8'd5;
        bus.mask  = 4'hF;
        bus.cont  = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      step();
    end
    bus.start = 1'b0;
    chk_out("ign_done", 2'd3, 1'b0, 1'b0, 1'b1);
    step();

    // Maximum dwell: div=255 on a single line gives 256 valid cycles.
    go(4'b1110, 8'd255, 1'b0);
    cnt = 0;
    while (bus.valid && cnt < 400) begin
      cnt++;
      step();
    end
    check("maxdwell_len", 32'(cnt), 32'd256);
    check("maxdwell_done", {31'd0, bus.done}, 32'd1);
    step();

    // Reset mid-scan while line 2 is active, then restart from line 0.
    go(4'b0000, 8'd3, 1'b0);
    for (int i = 0; i < 9; i++) step();
    chk_out("rst_pre", 2'd2, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_out("rst_mid", 2'd0, 1'b0, 1'b0, 1'b0);
    go(4'b0000, 8'd0, 1'b0);
    chk_out("rst_restart", 2'd0, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("rst_restart1", 2'd1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step();

`ifdef SCAN_REVERSE_EN
    // Descending scan, mask 0010, div=0: 3,2,0 then done.
    bus.dir = 1'b1;
    go(4'b0010, 8'd0, 1'b0);
    bus.dir = 1'b0;
    chk_out("rev_a", 2'd3, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("rev_b", 2'd2, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("rev_c", 2'd0, 1'b1, 1'b1, 1'b0);
    step();
    chk_out("rev_done", 2'd0, 1'b0, 1'b0, 1'b1);
    step();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
